// File: rtl/bsg_div_iterative_pkg.sv
// Shared types for the iterative restoring divider: FSM states and the flags
// latched alongside the operands when an operation is accepted.
package bsg_div_iterative_pkg;

  typedef enum logic [2:0] {
    eIDLE,
    eNEG,
    eCAL,
    eFIX,
    eDONE
  } state_e;

  // Raw sign bits are kept; signed_op decides whether they mean anything.
  typedef struct packed {
    logic signed_op;
    logic dividend_sign;
    logic divisor_sign;
    logic div_by_zero;
  } div_flags_s;

  function automatic logic is_dividend_neg(div_flags_s f);
    return f.signed_op & f.dividend_sign;
  endfunction

  function automatic logic is_divisor_neg(div_flags_s f);
    return f.signed_op & f.divisor_sign;
  endfunction

  function automatic logic is_quotient_neg(div_flags_s f);
    return f.signed_op & (f.dividend_sign ^ f.divisor_sign);
  endfunction

endpackage

// File: rtl/bsg_div_restoring_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, then
// subtract the divisor only if the shifted remainder is large enough.
module bsg_div_restoring_step
  import bsg_div_iterative_pkg::*;
#(
  parameter int width_p = 32
)
(
  input  logic [width_p-1:0] partial_rem,
  input  logic [width_p:0]   divisor,
  input  logic               next_bit,
  output logic [width_p-1:0] new_rem,
  output logic               q_bit
);

  logic [width_p:0]   shifted;
  logic [width_p-1:0] diff;

  assign shifted = {partial_rem, next_bit};
  assign q_bit   = (shifted >= divisor);

  // When the subtraction is kept the true difference is below 2^width_p,
  // so the low bits alone are exact.
  assign diff    = shifted[width_p-1:0] - divisor[width_p-1:0];
  assign new_rem = q_bit ? diff : shifted[width_p-1:0];

endmodule

// File: rtl/bsg_div_iterative.sv
// Iterative radix-2 restoring divider, signed or unsigned, one quotient bit per
// cycle. Define BSG_DIV_ITERATIVE_ZERO_BYPASS_EN to finish divide-by-zero in one cycle.
module bsg_div_iterative
  import bsg_div_iterative_pkg::*;
#(
  parameter int width_p = 32
)
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] dividend_i,
  input  logic [width_p-1:0] divisor_i,
  input  logic               signed_i,
  output logic [width_p-1:0] quotient_o,
  output logic [width_p-1:0] remainder_o,
  output logic               div_by_zero_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int cnt_width_lp = $clog2(width_p+1);

  state_e                  state_r, state_n;
  div_flags_s              flags_r;
  logic [width_p-1:0]      dividend_r, divisor_r;
  logic [width_p:0]        divisor_mag_r;
  logic [width_p-1:0]      rem_r, quot_r;
  logic [cnt_width_lp-1:0] cnt_r;
  logic [width_p-1:0]      quotient_r, remainder_r;
  logic                    dbz_r;

  logic                    accept, divisor_zero;
  logic [width_p-1:0]      step_rem;
  logic                    step_q;

  assign ready_o       = (state_r == eIDLE);
  assign v_o           = (state_r == eDONE);
  assign accept        = v_i & ready_o;
  assign divisor_zero  = (divisor_i == '0);
  assign quotient_o    = quotient_r;
  assign remainder_o   = remainder_r;
  assign div_by_zero_o = dbz_r;

  // quot_r doubles as the dividend shift register: its MSB feeds the step
  // and the new quotient bit enters at the bottom.
  bsg_div_restoring_step #(
    .width_p(width_p)
  ) restoring_step (
    .partial_rem(rem_r),
    .divisor    (divisor_mag_r),
    .next_bit   (quot_r[width_p-1]),
    .new_rem    (step_rem),
    .q_bit      (step_q)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) state_r <= eIDLE;
    else          state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      eIDLE: begin
        if (accept) begin
`ifdef BSG_DIV_ITERATIVE_ZERO_BYPASS_EN
          state_n = divisor_zero ? eDONE : eNEG;
`else
          state_n = eNEG;
`endif
        end
      end
      eNEG:    state_n = eCAL;
      eCAL:    if (cnt_r == '0) state_n = eFIX;
      eFIX:    state_n = eDONE;
      eDONE:   if (yumi_i) state_n = eIDLE;
      default: state_n = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      flags_r       <= '0;
      dividend_r    <= '0;
      divisor_r     <= '0;
      divisor_mag_r <= '0;
      rem_r         <= '0;
      quot_r        <= '0;
      cnt_r         <= '0;
      quotient_r    <= '0;
      remainder_r   <= '0;
      dbz_r         <= 1'b0;
    end else begin
      case (state_r)
        eIDLE: begin
          if (accept) begin
            dividend_r            <= dividend_i;
            divisor_r             <= divisor_i;
            flags_r.signed_op     <= signed_i;
            flags_r.dividend_sign <= dividend_i[width_p-1];
            flags_r.divisor_sign  <= divisor_i[width_p-1];
            flags_r.div_by_zero   <= divisor_zero;
`ifdef BSG_DIV_ITERATIVE_ZERO_BYPASS_EN
            if (divisor_zero) begin
              quotient_r  <= '1;
              remainder_r <= dividend_i;
              dbz_r       <= 1'b1;
            end
`endif
          end
        end
        eNEG: begin
          // Negating MIN wraps to 2^(width_p-1), which is exactly its magnitude.
          quot_r        <= is_dividend_neg(flags_r) ? -dividend_r : dividend_r;
          divisor_mag_r <= {1'b0, (is_divisor_neg(flags_r) ? -divisor_r : divisor_r)};
          rem_r         <= '0;
          cnt_r         <= cnt_width_lp'(width_p-1);
        end
        eCAL: begin
          rem_r  <= step_rem;
          quot_r <= {quot_r[width_p-2:0], step_q};
          cnt_r  <= cnt_r - cnt_width_lp'(1);
        end
        eFIX: begin
          dbz_r <= flags_r.div_by_zero;
          if (flags_r.div_by_zero) begin
            quotient_r  <= '1;
            remainder_r <= dividend_r;
          end else begin
            quotient_r  <= is_quotient_neg(flags_r) ? -quot_r : quot_r;
            remainder_r <= is_dividend_neg(flags_r) ? -rem_r : rem_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_div_iterative.sv
// Self-checking bench for bsg_div_iterative at width_p=32: directed corner cases,
// handshake/latency/reset-abort checks and a random sweep against a plain-arithmetic model.
module tb_bsg_div_iterative;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         v_i;
  logic         ready_o;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic         signed_i;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         div_by_zero_o;
  logic         v_o;
  logic         yumi_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_div_iterative #(
    .width_p(W)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .signed_i     (signed_i),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .div_by_zero_o(div_by_zero_o),
    .v_o          (v_o),
    .yumi_i       (yumi_i)
  );

  // Reference: native 64-bit division truncates toward zero and gives the
  // remainder the dividend's sign, which is exactly the required behaviour.
  function automatic void refDiv(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, output logic [W-1:0] q,
                                 output logic [W-1:0] r, output logic z);
    longint          sa, sb;
    longint unsigned ua, ub;
    z = (b == '0);
    if (z) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      ua = a;
      ub = b;
      q  = W'(ua / ub);
      r  = W'(ua % ub);
    end
  endfunction

  function automatic int expLatency(input logic [W-1:0] b);
`ifdef BSG_DIV_ITERATIVE_ZERO_BYPASS_EN
    if (b == '0) return 1;
`endif
    return W + 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic acceptOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
    v_i        = 1'b1;
    @(posedge clk);
    #1;
    v_i        = 1'b0;
    dividend_i = $urandom;
    divisor_i  = $urandom;
  endtask

  // Counts cycles from the accept edge (cycle 1) until v_o, bounded.
  task automatic waitResult(output int lat, output logic ready_leak);
    lat        = 1;
    ready_leak = 1'b0;
    while (v_o !== 1'b1 && lat < 200) begin
      if (ready_o !== 1'b0) ready_leak = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic s);
    int           lat;
    logic         leak;
    logic [W-1:0] eq, er;
    logic         ez;
    acceptOp(a, b, s);
    waitResult(lat, leak);
    refDiv(a, b, s, eq, er, ez);
    checkOutput({tag, "_latency"}, W'(lat), W'(expLatency(b)));
    checkOutput({tag, "_ready_low"}, W'(leak), '0);
    checkOutput({tag, "_q"}, quotient_o, eq);
    checkOutput({tag, "_r"}, remainder_o, er);
    checkOutput({tag, "_dbz"}, W'(div_by_zero_o), W'(ez));
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    yumi_i = 1'b1;
    @(posedge clk);
    #1;
    yumi_i = 1'b0;
    checkOutput({tag, "_ready_after_yumi"}, W'(ready_o), W'(1));
    checkOutput({tag, "_v_after_yumi"}, W'(v_o), '0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
  } op_t;

  initial begin
    op_t          dir [8];
    logic [W-1:0] eq, er, a, b;
    logic         ez, s;

    reset_i    = 1'b0;
    v_i        = 1'b0;
    yumi_i     = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    signed_i   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", W'(ready_o), W'(1));
    checkOutput("reset_v", W'(v_o), '0);
    checkOutput("reset_q", quotient_o, '0);
    checkOutput("reset_r", remainder_o, '0);
    checkOutput("reset_dbz", W'(div_by_zero_o), '0);
    @(negedge clk);
    reset_i = 1'b1;

    $display("[TB] directed cases");
    dir[0] = '{32'd100,        32'd7,          1'b0};
    dir[1] = '{32'hFFFFFFF9,   32'd2,          1'b1};
    dir[2] = '{32'd7,          32'hFFFFFFFE,   1'b1};
    dir[3] = '{32'h80000000,   32'hFFFFFFFF,   1'b1};
    dir[4] = '{32'hFFFFFFFF,   32'd1,          1'b0};
    dir[5] = '{32'h1234,       32'd0,          1'b0};
    dir[6] = '{32'h1234,       32'd0,          1'b1};
    dir[7] = '{32'd0,          32'd13,         1'b1};
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("dir%0d", i), dir[i].a, dir[i].b, dir[i].s);
      consume($sformatf("dir%0d", i));
    end
    applyStimulus("small_over_big", 32'hFFFFFFFB, 32'd9, 1'b1);
    consume("small_over_big");

    $display("[TB] hold result without yumi");
    applyStimulus("hold", 32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("hold_v", W'(v_o), W'(1));
    checkOutput("hold_q", quotient_o, 32'd14);
    checkOutput("hold_r", remainder_o, 32'd2);
    consume("hold");
    applyStimulus("b2b_a", 32'd1000, 32'd33, 1'b0);
    consume("b2b_a");
    applyStimulus("b2b_b", 32'hFFFFFC18, 32'd33, 1'b1);
    consume("b2b_b");

    $display("[TB] reset during calculation");
    acceptOp(32'hDEADBEEF, 32'h13, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_ready", W'(ready_o), W'(1));
    checkOutput("abort_v", W'(v_o), '0);
    checkOutput("abort_q", quotient_o, '0);
    checkOutput("abort_r", remainder_o, '0);
    checkOutput("abort_dbz", W'(div_by_zero_o), '0);
    @(negedge clk);
    reset_i = 1'b1;
    applyStimulus("after_abort", 32'd9, 32'd3, 1'b0);
    checkOutput("after_abort_q_const", quotient_o, 32'd3);
    checkOutput("after_abort_r_const", remainder_o, 32'd0);
    consume("after_abort");

    $display("[TB] random sweep");
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = W'($urandom_range(1, 20));
        2:       b = -W'($urandom_range(1, 20));
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = ($urandom_range(0, 3) == 0) ? '0 : 32'hFFFFFFFF;
      endcase
      s = 1'($urandom_range(0, 1));
      refDiv(a, b, s, eq, er, ez);
      applyStimulus($sformatf("rnd%0d", i), a, b, s);
      consume($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
